// File: rtl/clk_en_pkg.sv
// Shared CPU-mode encoding and tap-index helpers for the clock-enable generator.
package clk_en_pkg;

  typedef enum logic [1:0] {
    MODE_FAST = 2'b00,
    MODE_SLOW = 2'b01,
    MODE_STEP = 2'b10,
    MODE_HALT = 2'b11
  } cpu_mode_e;

  function automatic int sel_width(input int cnt_w);
    int w;
    w = 0;
    while ((1 << w) < cnt_w) w++;
    return (w < 1) ? 1 : w;
  endfunction

  // Taps beyond the top counter bit fall back to the slowest available tap.
  function automatic int clamp_tap(input int sel, input int cnt_w);
    return (sel >= cnt_w) ? cnt_w - 1 : sel;
  endfunction

endpackage

// File: rtl/clk_tap_sel.sv
// One programmable tap: raises a single-cycle tick when the selected counter
// bit has just risen (cnt[k:0] == 2^k), with out-of-range selects clamped.
module clk_tap_sel
  import clk_en_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic [SEL_W-1:0] sel,
  output logic             hit,
  output logic             tick
);

  logic [CNT_W-1:0] one_hot;
  logic [CNT_W-1:0] low_mask;
  logic             tick_q;
  logic             tick_d;

  // Suppressing a hit right after a tick keeps a select change from
  // stretching the pulse into two back-to-back cycles.
  always_comb begin
    one_hot  = CNT_W'(1) << clamp_tap(int'(sel), CNT_W);
    low_mask = one_hot | (one_hot - CNT_W'(1));
    hit      = ((cnt & low_mask) == one_hot) && !tick_q;
    tick_d   = hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/clk_en_gen.sv
// Clock-enable generator: free-running counter, NCH tap channels and a CPU
// enable whose fast/slow/step/halt mode only changes on period boundaries.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int NCH   = 2,
  parameter int SEL_W = sel_width(CNT_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [SEL_W-1:0]     fast_sel,
  input  logic [SEL_W-1:0]     slow_sel,
  input  logic                 step_btn,
  input  logic [NCH*SEL_W-1:0] ch_sel,
  output logic [CNT_W-1:0]     clkdiv,
  output logic [NCH-1:0]       ch_tick,
  output logic                 cpu_en,
  output logic [1:0]           mode_q
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic             cpu_en_q, cpu_en_d;
  cpu_mode_e        cur_mode_q, mode_d;
  logic             step_edge;
  logic             fast_hit;
  logic             slow_hit;
  logic             fast_tick_unused;
  logic             slow_tick_unused;
  logic [NCH-1:0]   ch_hit_unused;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_tap_sel #(
      .CNT_W(CNT_W),
      .SEL_W(SEL_W)
    ) u_tap (
      .clk (clk),
      .rst (rst),
      .cnt (cnt_q),
      .sel (ch_sel[i*SEL_W +: SEL_W]),
      .hit (ch_hit_unused[i]),
      .tick(ch_tick[i])
    );
  end

  clk_tap_sel #(
    .CNT_W(CNT_W),
    .SEL_W(SEL_W)
  ) u_fast_tap (
    .clk (clk),
    .rst (rst),
    .cnt (cnt_q),
    .sel (fast_sel),
    .hit (fast_hit),
    .tick(fast_tick_unused)
  );

  clk_tap_sel #(
    .CNT_W(CNT_W),
    .SEL_W(SEL_W)
  ) u_slow_tap (
    .clk (clk),
    .rst (rst),
    .cnt (cnt_q),
    .sel (slow_sel),
    .hit (slow_hit),
    .tick(slow_tick_unused)
  );

  // Fast/slow modes only hand over on their own boundary, and that boundary
  // pulse still goes out under the old mode; step/halt hand over at once.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    s1_d      = step_btn;
    s2_d      = s1_q;
    s3_d      = s2_q;
    step_edge = s2_q & ~s3_q;
    mode_d    = cur_mode_q;
    cpu_en_d  = 1'b0;
    case (cur_mode_q)
      MODE_FAST: begin
        cpu_en_d = fast_hit;
        if (fast_hit) mode_d = cpu_mode_e'(mode);
      end
      MODE_SLOW: begin
        cpu_en_d = slow_hit;
        if (slow_hit) mode_d = cpu_mode_e'(mode);
      end
      MODE_STEP: begin
        cpu_en_d = step_edge;
        mode_d   = cpu_mode_e'(mode);
      end
      MODE_HALT: begin
        mode_d = cpu_mode_e'(mode);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      cpu_en_q   <= 1'b0;
      cur_mode_q <= MODE_FAST;
    end else begin
      cnt_q      <= cnt_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      cpu_en_q   <= cpu_en_d;
      cur_mode_q <= mode_d;
    end
  end

  assign clkdiv = cnt_q;
  assign cpu_en = cpu_en_q;
  assign mode_q = cur_mode_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: tap timing table, mode handover, single-step,
// halt, async reset mid-step, and tap clamping on a narrow-counter instance.
module tb_clk_en_gen;
  import clk_en_pkg::*;

  localparam int CNT_W    = 32;
  localparam int NCH      = 2;
  localparam int SEL_W    = 5;
  localparam int SM_CNT_W = 6;
  localparam int SM_SEL_W = 3;
  localparam int NV       = 24;

  typedef struct {
    int         edge_no;
    logic [1:0] mode_req;
    logic [1:0] exp_ch;
    logic       exp_cpu;
    logic [1:0] exp_mode;
    logic       exp_small;
  } vec_t;

  logic                 clk;
  logic                 rst;
  logic [1:0]           mode;
  logic [SEL_W-1:0]     fast_sel;
  logic [SEL_W-1:0]     slow_sel;
  logic                 step_btn;
  logic [NCH*SEL_W-1:0] ch_sel;
  logic [CNT_W-1:0]     clkdiv;
  logic [NCH-1:0]       ch_tick;
  logic                 cpu_en;
  logic [1:0]           mode_q;

  logic [SM_CNT_W-1:0]  sm_clkdiv;
  logic [0:0]           sm_tick;
  logic                 sm_cpu;
  logic [1:0]           sm_mode;

  int   checks;
  int   failures;
  int   edges;
  int   cpu_cnt;
  int   ch0_cnt;
  vec_t vecs[NV];

  clk_en_gen #(
    .CNT_W(CNT_W),
    .NCH  (NCH),
    .SEL_W(SEL_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .fast_sel(fast_sel),
    .slow_sel(slow_sel),
    .step_btn(step_btn),
    .ch_sel  (ch_sel),
    .clkdiv  (clkdiv),
    .ch_tick (ch_tick),
    .cpu_en  (cpu_en),
    .mode_q  (mode_q)
  );

  // Narrow counter so that select 7 must clamp to tap 5 (period 64).
  clk_en_gen #(
    .CNT_W(SM_CNT_W),
    .NCH  (1),
    .SEL_W(SM_SEL_W)
  ) dut_small (
    .clk     (clk),
    .rst     (rst),
    .mode    (2'b00),
    .fast_sel(3'd7),
    .slow_sel(3'd0),
    .step_btn(1'b0),
    .ch_sel  (3'd7),
    .clkdiv  (sm_clkdiv),
    .ch_tick (sm_tick),
    .cpu_en  (sm_cpu),
    .mode_q  (sm_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s edge=%0d got=%0h want=%0h", name, edges, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    edges = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    edges    = 0;
    rst      = 1'b1;
    mode     = MODE_FAST;
    fast_sel = 5'd2;
    slow_sel = 5'd4;
    step_btn = 1'b0;
    ch_sel   = {5'd3, 5'd0};

    // Tap checkpoints after reset release: ch0 every even edge, ch1 at 9+16n,
    // fast(sel 2) at 5+8n; slow(sel 4) requested from edge 7 takes over at the
    // fast boundary (edge 13), then fires at 17, 49; fast requested from edge
    // 50 takes over at the slow boundary (edge 81), next fast pulse at 85.
    vecs[0]  = '{1,  MODE_FAST, 2'b00, 1'b0, MODE_FAST, 1'b0};
    vecs[1]  = '{2,  MODE_FAST, 2'b01, 1'b0, MODE_FAST, 1'b0};
    vecs[2]  = '{4,  MODE_FAST, 2'b01, 1'b0, MODE_FAST, 1'b0};
    vecs[3]  = '{5,  MODE_FAST, 2'b00, 1'b1, MODE_FAST, 1'b0};
    vecs[4]  = '{6,  MODE_FAST, 2'b01, 1'b0, MODE_FAST, 1'b0};
    vecs[5]  = '{7,  MODE_SLOW, 2'b00, 1'b0, MODE_FAST, 1'b0};
    vecs[6]  = '{9,  MODE_SLOW, 2'b10, 1'b0, MODE_FAST, 1'b0};
    vecs[7]  = '{12, MODE_SLOW, 2'b01, 1'b0, MODE_FAST, 1'b0};
    vecs[8]  = '{13, MODE_SLOW, 2'b00, 1'b1, MODE_SLOW, 1'b0};
    vecs[9]  = '{14, MODE_SLOW, 2'b01, 1'b0, MODE_SLOW, 1'b0};
    vecs[10] = '{16, MODE_SLOW, 2'b01, 1'b0, MODE_SLOW, 1'b0};
    vecs[11] = '{17, MODE_SLOW, 2'b00, 1'b1, MODE_SLOW, 1'b0};
    vecs[12] = '{21, MODE_SLOW, 2'b00, 1'b0, MODE_SLOW, 1'b0};
    vecs[13] = '{25, MODE_SLOW, 2'b10, 1'b0, MODE_SLOW, 1'b0};
    vecs[14] = '{32, MODE_SLOW, 2'b01, 1'b0, MODE_SLOW, 1'b0};
    vecs[15] = '{33, MODE_SLOW, 2'b00, 1'b0, MODE_SLOW, 1'b1};
    vecs[16] = '{34, MODE_SLOW, 2'b01, 1'b0, MODE_SLOW, 1'b0};
    vecs[17] = '{48, MODE_SLOW, 2'b01, 1'b0, MODE_SLOW, 1'b0};
    vecs[18] = '{49, MODE_SLOW, 2'b00, 1'b1, MODE_SLOW, 1'b0};
    vecs[19] = '{50, MODE_FAST, 2'b01, 1'b0, MODE_SLOW, 1'b0};
    vecs[20] = '{57, MODE_FAST, 2'b10, 1'b0, MODE_SLOW, 1'b0};
    vecs[21] = '{81, MODE_FAST, 2'b00, 1'b1, MODE_FAST, 1'b0};
    vecs[22] = '{85, MODE_FAST, 2'b00, 1'b1, MODE_FAST, 1'b0};
    vecs[23] = '{86, MODE_FAST, 2'b01, 1'b0, MODE_FAST, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_clkdiv", clkdiv, 32'd0);
    check_output("reset_ch_tick", 32'(ch_tick), 32'd0);
    check_output("reset_cpu_en", 32'(cpu_en), 32'd0);
    check_output("reset_mode_q", 32'(mode_q), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    edges = 0;

    for (int r = 0; r < NV; r++) begin
      mode = vecs[r].mode_req;
      while (edges < vecs[r].edge_no) step_clk();
      check_output("tbl_clkdiv", clkdiv, 32'(edges));
      check_output("tbl_ch_tick", 32'(ch_tick), 32'(vecs[r].exp_ch));
      check_output("tbl_cpu_en", 32'(cpu_en), 32'(vecs[r].exp_cpu));
      check_output("tbl_mode_q", 32'(mode_q), 32'(vecs[r].exp_mode));
      check_output("tbl_small_tick", 32'(sm_tick), 32'(vecs[r].exp_small));
      check_output("tbl_small_cpu", 32'(sm_cpu), 32'(vecs[r].exp_small));
      check_output("tbl_small_clkdiv", 32'(sm_clkdiv), 32'(edges % 64));
      check_output("tbl_small_mode", 32'(sm_mode), 32'd0);
    end

    // Step mode: handover at fast boundary (edge 5), one pulse per press.
    mode     = MODE_STEP;
    step_btn = 1'b0;
    do_reset();
    for (int e = 1; e <= 45; e++) begin
      step_btn = ((e >= 10 && e <= 29) || (e >= 35 && e <= 39));
      step_clk();
      check_output("step_cpu_en", 32'(cpu_en), 32'(e == 5 || e == 12 || e == 37));
      check_output("step_mode_q", 32'(mode_q), (e >= 5) ? 32'd2 : 32'd0);
    end

    // Halt: enable silent, channels keep ticking; a press made during halt
    // must not produce a pulse once step mode is entered.
    mode = MODE_HALT;
    step_clk();
    check_output("halt_mode_q", 32'(mode_q), 32'd3);
    step_btn = 1'b1;
    cpu_cnt  = 0;
    ch0_cnt  = 0;
    for (int i = 0; i < 1000; i++) begin
      step_clk();
      cpu_cnt += int'(cpu_en);
      ch0_cnt += int'(ch_tick[0]);
    end
    check_output("halt_cpu_pulses", 32'(cpu_cnt), 32'd0);
    check_output("halt_ch0_pulses", 32'(ch0_cnt), 32'd500);
    check_output("halt_mode_hold", 32'(mode_q), 32'd3);
    mode = MODE_STEP;
    step_clk();
    check_output("halt_to_step_mode", 32'(mode_q), 32'd2);
    cpu_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step_clk();
      cpu_cnt += int'(cpu_en);
    end
    check_output("stale_press_pulses", 32'(cpu_cnt), 32'd0);
    step_btn = 1'b0;
    repeat (4) step_clk();

    // Async reset while a press is inside the synchroniser.
    step_btn = 1'b1;
    step_clk();
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst_clkdiv", clkdiv, 32'd0);
    check_output("async_rst_ch_tick", 32'(ch_tick), 32'd0);
    check_output("async_rst_cpu_en", 32'(cpu_en), 32'd0);
    check_output("async_rst_mode_q", 32'(mode_q), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    edges = 0;
    for (int e = 1; e <= 12; e++) begin
      step_clk();
      check_output("post_rst_cpu_en", 32'(cpu_en), 32'(e == 5));
      check_output("post_rst_mode_q", 32'(mode_q), (e >= 5) ? 32'd2 : 32'd0);
    end
    step_btn = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
